// File: rtl/hs_in_poll_ctrl_pkg.sv
// Shared definitions for the hs_parallel_in polling controller:
// register-select codes, FSM state encoding and the default "byte ready" status bit.
package hs_in_poll_ctrl_pkg;

    localparam logic A0_DATA   = 1'b0;
    localparam logic A0_STATUS = 1'b1;

    localparam int DEFAULT_FI_BIT = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ST_SET = 3'd1,
        S_ST_RD  = 3'd2,
        S_ST_END = 3'd3,
        S_DT_SET = 3'd4,
        S_DT_RD  = 3'd5,
        S_DT_END = 3'd6
    } poll_state_e;

endpackage

// File: rtl/hs_in_poll_ctrl_if.sv
// Bus bundle between the polling controller, the hs_parallel_in register port
// and the downstream byte consumer.
interface hs_in_poll_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic          s_;
    logic          ior_;
    logic          a0;
    logic [7:0]    d7_d0;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          byte_ready;
    logic [FW-1:0] fill;
    logic [15:0]   rx_count;

    modport master (
        output s_, ior_, a0, byte_out, byte_valid, fill, rx_count,
        input  d7_d0, byte_ready
    );

    modport slave (
        input  s_, ior_, a0, byte_out, byte_valid, fill, rx_count,
        output d7_d0, byte_ready
    );

endinterface

// File: rtl/hs_in_poll_ctrl_fifo.sv
// Byte FIFO (DEPTH x 8) with synchronous active-low reset; the head is always
// presented on dout and a simultaneous push/pop leaves the occupancy unchanged.
module hs_in_poll_ctrl_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [FW-1:0] r_fill;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = pop && (r_fill != {FW{1'b0}});
    assign w_push = push && (r_fill != FULL);

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_fill   <= {FW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign valid = (r_fill != {FW{1'b0}});
    assign fill  = r_fill;

endmodule

// File: rtl/hs_in_poll_ctrl.sv
// Bus-side controller for hs_parallel_in: polls the status register, reads the
// data register when a byte is ready and buffers the bytes for a valid/ready consumer.
module hs_in_poll_ctrl
    import hs_in_poll_ctrl_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int RD_CYCLES = 2,
    parameter int FI_BIT    = DEFAULT_FI_BIT
) (
    input  logic              clock,
    input  logic              reset_,
    input  logic              enable,
    hs_in_poll_ctrl_if.master bus
);
    localparam int FW = $clog2(DEPTH) + 1;
    localparam int CW = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
    localparam logic [FW-1:0] FULL    = FW'(DEPTH);
    localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);

    poll_state_e   r_state;
    logic [CW-1:0] r_cnt;
    logic          r_s_;
    logic          r_ior_;
    logic          r_a0;
    logic          r_stat_fi;
    logic [7:0]    r_data;
    logic [15:0]   r_rx_count;

    logic          w_start;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_dout;
    logic          w_valid;
    logic [FW-1:0] w_fill;

    assign w_start = enable && (w_fill < FULL);
    assign w_push  = (r_state == S_DT_END);
    assign w_pop   = w_valid && bus.byte_ready;

    // Poll FSM: every bus strobe is a register, set on entry to the state it belongs to.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CW{1'b0}};
            r_s_       <= 1'b1;
            r_ior_     <= 1'b1;
            r_a0       <= A0_DATA;
            r_stat_fi  <= 1'b0;
            r_data     <= 8'h00;
            r_rx_count <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_s_   <= 1'b1;
                    r_ior_ <= 1'b1;
                    if (w_start) begin
                        r_state <= S_ST_SET;
                        r_s_    <= 1'b0;
                        r_a0    <= A0_STATUS;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ST_SET: begin
                    r_ior_  <= 1'b0;
                    r_cnt   <= RD_LAST;
                    r_state <= S_ST_RD;
                end
                S_ST_RD: begin
                    if (r_cnt == {CW{1'b0}}) begin
                        r_stat_fi <= bus.d7_d0[FI_BIT];
                        r_s_      <= 1'b1;
                        r_ior_    <= 1'b1;
                        r_state   <= S_ST_END;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_ST_END: begin
                    // a0 moves only here and in IDLE, where ior_ is already high.
                    if (r_stat_fi) begin
                        r_state <= S_DT_SET;
                        r_s_    <= 1'b0;
                        r_a0    <= A0_DATA;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DT_SET: begin
                    r_ior_  <= 1'b0;
                    r_cnt   <= RD_LAST;
                    r_state <= S_DT_RD;
                end
                S_DT_RD: begin
                    if (r_cnt == {CW{1'b0}}) begin
                        r_data  <= bus.d7_d0;
                        r_s_    <= 1'b1;
                        r_ior_  <= 1'b1;
                        r_state <= S_DT_END;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DT_END: begin
                    r_rx_count <= r_rx_count + 16'd1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_s_    <= 1'b1;
                    r_ior_  <= 1'b1;
                    r_a0    <= A0_DATA;
                end
            endcase
        end
    end

    hs_in_poll_ctrl_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset_ (reset_),
        .push   (w_push),
        .din    (r_data),
        .pop    (w_pop),
        .dout   (w_dout),
        .valid  (w_valid),
        .fill   (w_fill)
    );

    assign bus.s_         = r_s_;
    assign bus.ior_       = r_ior_;
    assign bus.a0         = r_a0;
    assign bus.byte_out   = w_dout;
    assign bus.byte_valid = w_valid;
    assign bus.fill       = w_fill;
    assign bus.rx_count   = r_rx_count;

endmodule

// File: tb/tb_hs_in_poll_ctrl.sv
// Bench for hs_in_poll_ctrl with a behavioural hs_parallel_in (dav_/rfd producer
// side, status/data registers) and a byte scoreboard on the consumer side.
module tb_hs_in_poll_ctrl;

    logic clock = 1'b0;
    logic reset_;
    logic enable;

    hs_in_poll_ctrl_if #(.DEPTH(4)) bus ();

    hs_in_poll_ctrl #(
        .DEPTH     (4),
        .RD_CYCLES (2),
        .FI_BIT    (0)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .enable (enable),
        .bus    (bus)
    );

    always #3 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Interface model: producer loads on dav_ low, data-register read frees it.
    logic       dav_  = 1'b1;
    logic [7:0] pdata = 8'h00;
    logic       p_full = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       p_seen = 1'b0;
    logic       rfd;
    assign rfd = !p_full;
    assign bus.d7_d0 = (!bus.s_ && !bus.ior_) ? (bus.a0 ? {7'b0000000, p_full} : p_data) : 8'hFF;

    always @(posedge clock) begin
        if (!dav_ && !p_full) begin
            p_full <= 1'b1;
            p_data <= pdata;
        end else if (p_seen && bus.ior_) begin
            p_full <= 1'b0;
            p_seen <= 1'b0;
        end else if (!bus.s_ && !bus.ior_ && !bus.a0) begin
            p_seen <= 1'b1;
        end
    end

    // Bus monitor and consumer scoreboard, sampled on the falling edge.
    logic [7:0] exp_q[$];
    int cyc = 0, n_s_fall = 0, n_data_reads = 0, n_bad_ior = 0, n_bad_a0 = 0;
    int last_fall = 0, prev_fall = 0;
    logic prev_s = 1'b1, prev_ior = 1'b1, prev_a0 = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (prev_s === 1'b1 && bus.s_ === 1'b0) begin
            n_s_fall++;
            prev_fall = last_fall;
            last_fall = cyc;
        end
        if (prev_ior === 1'b1 && bus.ior_ === 1'b0 && bus.a0 === 1'b0) n_data_reads++;
        if (bus.ior_ === 1'b0 && bus.s_ !== 1'b0) n_bad_ior++;
        if (bus.a0 !== prev_a0 && (bus.ior_ !== 1'b1 || prev_ior !== 1'b1)) n_bad_a0++;
        prev_s = bus.s_;
        prev_ior = bus.ior_;
        prev_a0 = bus.a0;
        if (reset_ === 1'b1 && bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, bus.byte_out}, 32'hFFFF_FFFF);
            else chk("byte_order", {24'h0, bus.byte_out}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        while (!rfd && t < 300) begin tick(); t++; end
        chk("rfd_wait", {31'h0, rfd}, 32'h1);
        pdata = b;
        dav_ = 1'b0;
        exp_q.push_back(b);
        tick();
        dav_ = 1'b1;
    endtask

    task automatic wait_fill(input int f, input string tag);
        int t = 0;
        while (int'(bus.fill) != f && t < 200) begin tick(); t++; end
        chk(tag, 32'(bus.fill), 32'(f));
    endtask

    task automatic wait_bus(input logic a0v, input string tag);
        int t = 0;
        while (!(bus.s_ === 1'b0 && bus.ior_ === 1'b0 && bus.a0 === a0v) && t < 100) begin tick(); t++; end
        chk(tag, {31'h0, bus.ior_}, 32'h0);
    endtask

    initial begin
        int snap;
        int t;
        reset_ = 1'b0;
        enable = 1'b0;
        bus.byte_ready = 1'b0;

        // 1: reset
        tick(); tick();
        chk("rst_s_", {31'h0, bus.s_}, 32'h1);
        chk("rst_ior_", {31'h0, bus.ior_}, 32'h1);
        chk("rst_a0", {31'h0, bus.a0}, 32'h0);
        chk("rst_byte_out", {24'h0, bus.byte_out}, 32'h0);
        chk("rst_valid", {31'h0, bus.byte_valid}, 32'h0);
        chk("rst_fill", 32'(bus.fill), 32'h0);
        chk("rst_rx_count", {16'h0, bus.rx_count}, 32'h0);
        reset_ = 1'b1;

        // 2: status-only polling
        enable = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        chk("poll_period", 32'(last_fall - prev_fall), 32'd5);
        chk("poll_running", {31'h0, (n_s_fall >= 6)}, 32'h1);
        chk("no_data_read", 32'(n_data_reads), 32'h0);
        chk("idle_fill", 32'(bus.fill), 32'h0);

        // 3: single byte
        send(8'h4F);
        wait_fill(1, "one_fill");
        chk("one_byte_out", {24'h0, bus.byte_out}, 32'h4F);
        chk("one_valid", {31'h0, bus.byte_valid}, 32'h1);
        chk("one_rx_count", {16'h0, bus.rx_count}, 32'h1);
        chk("one_rfd", {31'h0, rfd}, 32'h1);
        chk("one_data_reads", 32'(n_data_reads), 32'h1);
        bus.byte_ready = 1'b1;
        tick();
        bus.byte_ready = 1'b0;

        // 4: fill to DEPTH, fifth byte held by the interface
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        wait_fill(4, "full_fill");
        tick(); tick();
        snap = n_s_fall;
        for (int i = 0; i < 20; i++) tick();
        chk("full_no_poll", 32'(n_s_fall - snap), 32'h0);
        chk("full_held", {31'h0, rfd}, 32'h0);
        chk("full_rx_count", {16'h0, bus.rx_count}, 32'h5);
        chk("full_head", {24'h0, bus.byte_out}, 32'h11);
        bus.byte_ready = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || bus.fill != 3'd0) && t < 200) begin tick(); t++; end
        bus.byte_ready = 1'b0;
        chk("drain_empty", 32'(exp_q.size()), 32'h0);
        chk("drain_rx_count", {16'h0, bus.rx_count}, 32'h6);

        // 5: push and pop in the same cycle at fill=1
        send(8'hA1);
        wait_fill(1, "pp_fill_a");
        send(8'hA2);
        wait_bus(1'b0, "pp_data_rd");
        t = 0;
        while (bus.ior_ !== 1'b1 && t < 10) begin tick(); t++; end
        bus.byte_ready = 1'b1;
        tick();
        bus.byte_ready = 1'b0;
        chk("pp_fill", 32'(bus.fill), 32'h1);
        chk("pp_head", {24'h0, bus.byte_out}, 32'hA2);
        bus.byte_ready = 1'b1;
        tick();
        bus.byte_ready = 1'b0;

        // 6a: enable dropped mid status read still completes the transfer
        enable = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        send(8'hB5);
        enable = 1'b1;
        wait_bus(1'b1, "en_st_rd");
        enable = 1'b0;
        wait_fill(1, "en_fill");
        chk("en_byte_out", {24'h0, bus.byte_out}, 32'hB5);
        chk("en_rx_count", {16'h0, bus.rx_count}, 32'h9);
        snap = n_s_fall;
        for (int i = 0; i < 20; i++) tick();
        chk("en_stopped", 32'(n_s_fall - snap), 32'h0);
        chk("en_s_idle", {31'h0, bus.s_}, 32'h1);
        bus.byte_ready = 1'b1;
        tick();
        bus.byte_ready = 1'b0;

        // 6b: reset during data read discards the byte
        enable = 1'b1;
        send(8'hC3);
        wait_bus(1'b0, "rst_dt_rd");
        reset_ = 1'b0;
        tick();
        chk("mid_rst_ior_", {31'h0, bus.ior_}, 32'h1);
        chk("mid_rst_s_", {31'h0, bus.s_}, 32'h1);
        chk("mid_rst_fill", 32'(bus.fill), 32'h0);
        chk("mid_rst_valid", {31'h0, bus.byte_valid}, 32'h0);
        chk("mid_rst_rx", {16'h0, bus.rx_count}, 32'h0);
        reset_ = 1'b1;
        enable = 1'b0;
        void'(exp_q.pop_back());
        for (int i = 0; i < 10; i++) tick();
        chk("post_rst_fill", 32'(bus.fill), 32'h0);

        chk("bus_ior_rule", 32'(n_bad_ior), 32'h0);
        chk("bus_a0_rule", 32'(n_bad_a0), 32'h0);
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
